// File: rtl/umi_xbar_pkg.sv
// Shared UMI crossbar definitions: cmd field positions, address-decode defaults
// and the pointer-width helper used by the arbiters.
package umi_xbar_pkg;

    localparam int unsigned EOMBIT_DEF = 22;
    localparam int unsigned IDLSB_DEF  = 40;
    localparam int unsigned IDW_DEF    = 16;

    // cmd field positions common to all UMI blocks
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_W   = 5;
    localparam int unsigned SIZE_LSB   = 5;
    localparam int unsigned SIZE_W     = 3;
    localparam int unsigned LEN_LSB    = 8;
    localparam int unsigned LEN_W      = 8;

    // Index width for an N-entry selector, never less than one bit
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/umi_xbar_rr_arb.sv
// Per-output round-robin arbiter with packet lock: a non-EOM transfer pins the
// grant to its owner until the EOM beat, which then advances the pointer.
module umi_xbar_rr_arb
    import umi_xbar_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [N-1:0] req,
    input  logic         xfer,
    input  logic         eom,
    output logic [N-1:0] grant_c
);

    localparam int unsigned PW = ptr_width(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic          lock;
    logic [PW-1:0] winner_c;
    logic [PW-1:0] idx;
    logic          found;

    // Locked: only the owner may win; unlocked: first requester from ptr onward
    always_comb begin
        grant_c  = '0;
        winner_c = owner;
        idx      = '0;
        found    = 1'b0;
        if (lock) begin
            if (req[owner]) begin
                grant_c[owner] = 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = PW'((32'(ptr) + k) % N);
                if (!found && req[idx]) begin
                    found        = 1'b1;
                    winner_c     = idx;
                    grant_c[idx] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ptr   <= '0;
            owner <= '0;
            lock  <= 1'b0;
        end else if (xfer) begin
            if (eom) begin
                lock <= 1'b0;
                ptr  <= PW'((32'(winner_c) + 32'd1) % N);
            end else begin
                lock  <= 1'b1;
                owner <= winner_c;
            end
        end
    end

endmodule

// File: rtl/umi_xbar_rr.sv
// N-port UMI crossbar: decodes the destination port from dstaddr, arbitrates
// each output round-robin with packet locking, and muxes the zero-latency datapath.
module umi_xbar_rr
    import umi_xbar_pkg::*;
#(
    parameter int unsigned N       = 4,
    parameter int unsigned CW      = 32,
    parameter int unsigned AW      = 64,
    parameter int unsigned DW      = 256,
    parameter int unsigned IDLSB   = IDLSB_DEF,
    parameter int unsigned IDW     = IDW_DEF,
    parameter int unsigned DEFPORT = 0,
    parameter int unsigned EOMBIT  = EOMBIT_DEF
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic [N*N-1:0]  mask,
    input  logic [N-1:0]    umi_in_valid,
    output logic [N-1:0]    umi_in_ready,
    input  logic [N*CW-1:0] umi_in_cmd,
    input  logic [N*AW-1:0] umi_in_dstaddr,
    input  logic [N*AW-1:0] umi_in_srcaddr,
    input  logic [N*DW-1:0] umi_in_data,
    output logic [N-1:0]    umi_out_valid,
    input  logic [N-1:0]    umi_out_ready,
    output logic [N*CW-1:0] umi_out_cmd,
    output logic [N*AW-1:0] umi_out_dstaddr,
    output logic [N*AW-1:0] umi_out_srcaddr,
    output logic [N*DW-1:0] umi_out_data
);

    localparam int unsigned PW = ptr_width(N);

    logic [PW-1:0]  dest  [N];
    logic [N-1:0]   req   [N];
    logic [N-1:0]   grant [N];
    logic [N-1:0]   xfer;
    logic [N-1:0]   eom;
    logic [IDW-1:0] id;

    // Destination decode; out-of-range IDs fall back to the default port
    always_comb begin
        id = '0;
        for (int i = 0; i < int'(N); i++) begin
            id      = umi_in_dstaddr[i*AW+IDLSB +: IDW];
            dest[i] = (id < IDW'(N)) ? PW'(id) : PW'(DEFPORT);
        end
    end

    // Request matrix, indexed [output][input]
    always_comb begin
        for (int j = 0; j < int'(N); j++) begin
            req[j] = '0;
            for (int i = 0; i < int'(N); i++) begin
                req[j][i] = umi_in_valid[i] & (dest[i] == PW'(j)) & ~mask[j*N+i];
            end
        end
    end

    for (genvar j = 0; j < int'(N); j++) begin : g_out
        assign xfer[j] = umi_out_valid[j] & umi_out_ready[j];
        assign eom[j]  = umi_out_cmd[j*CW+EOMBIT];

        umi_xbar_rr_arb #(.N(N)) u_arb (
            .clk     (clk),
            .nreset  (nreset),
            .req     (req[j]),
            .xfer    (xfer[j]),
            .eom     (eom[j]),
            .grant_c (grant[j])
        );
    end

    // One-hot output muxes; everything reads zero while reset is asserted
    always_comb begin
        umi_out_valid   = '0;
        umi_out_cmd     = '0;
        umi_out_dstaddr = '0;
        umi_out_srcaddr = '0;
        umi_out_data    = '0;
        if (nreset) begin
            for (int j = 0; j < int'(N); j++) begin
                umi_out_valid[j] = |grant[j];
                for (int i = 0; i < int'(N); i++) begin
                    if (grant[j][i]) begin
                        umi_out_cmd[j*CW +: CW]     |= umi_in_cmd[i*CW +: CW];
                        umi_out_dstaddr[j*AW +: AW] |= umi_in_dstaddr[i*AW +: AW];
                        umi_out_srcaddr[j*AW +: AW] |= umi_in_srcaddr[i*AW +: AW];
                        umi_out_data[j*DW +: DW]    |= umi_in_data[i*DW +: DW];
                    end
                end
            end
        end
    end

    always_comb begin
        umi_in_ready = '0;
        for (int i = 0; i < int'(N); i++) begin
            umi_in_ready[i] = nreset & umi_out_ready[dest[i]] & grant[dest[i]][i];
        end
    end

endmodule
